// File: rtl/gate_checker_pkg.sv
// gate_checker_pkg: shared state encoding and reference truth tables for gate_checker
package gate_checker_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam logic [3:0] TRUTH_AND  = 4'b1000;
  localparam logic [3:0] TRUTH_OR   = 4'b1110;
  localparam logic [3:0] TRUTH_XOR  = 4'b0110;
  localparam logic [3:0] TRUTH_NAND = 4'b0111;
endpackage

// File: rtl/gc_hold_timer.sv
// gc_hold_timer: counts HOLD_CYCLES cycles per vector and flags the last hold cycle
module gc_hold_timer #(
  parameter int HOLD_CYCLES = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(HOLD_CYCLES);
  logic [W-1:0] cnt;
  always_comb tc = en && (cnt == W'(HOLD_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/gate_checker.sv
// gate_checker: sweeps {a,b} through 00..11 and scores a gate output against TRUTH
module gate_checker
  import gate_checker_pkg::*;
#(
  parameter int         HOLD_CYCLES = 50,
  parameter logic [3:0] TRUTH       = TRUTH_AND
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);
  state_t     state, state_n;
  logic [1:0] idx;
  logic       tc;
  gc_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(state != RUN),
    .en   (state == RUN),
    .tc   (tc)
  );
  always_comb begin
    state_n = state;
    if (state == RUN) state_n = (tc && &idx) ? DONE : RUN;
    else if (start) state_n = RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      state <= state_n;
      if (state != RUN && start) begin
        idx       <= '0;
        err_count <= '0;
        fail_vec  <= '0;
      end else if (state == RUN && tc) begin
        if (dut_out != TRUTH[idx]) begin
          err_count     <= err_count + 3'd1;
          fail_vec[idx] <= 1'b1;
        end
        if (!(&idx)) idx <= idx + 2'd1;
      end
    end
  end
  // idx only leaves 0 during a sweep and parks at 3 in DONE, so it doubles as the stimulus
  always_comb begin
    a    = idx[1];
    b    = idx[0];
    busy = state == RUN;
    done = state == DONE;
    pass = done && err_count == 3'd0;
  end
endmodule

// File: tb/tb_gate_checker.sv
// tb_gate_checker: three checkers with different truth tables share one stimulus
module tb_gate_checker;
  import gate_checker_pkg::*;
  logic clk = 0, rst = 1, start = 0;
  logic [1:0] mode = 0;
  logic a0, b0, busy0, done0, pass0, o0;
  logic a1, b1, busy1, done1, pass1, o1;
  logic a2, b2, busy2, done2, pass2, o2;
  logic [2:0] e0, e1, e2;
  logic [3:0] f0, f1, f2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  function automatic logic model(input logic [1:0] m, input logic x, input logic y);
    return m == 2'd0 ? (x & y) : m == 2'd1 ? 1'b0 : m == 2'd2 ? 1'b1 : (x ^ y);
  endfunction
  assign o0 = model(mode, a0, b0);
  assign o1 = model(mode, a1, b1);
  assign o2 = model(mode, a2, b2);

  gate_checker #(.HOLD_CYCLES(4), .TRUTH(TRUTH_AND)) u_and (
    .clk(clk), .rst(rst), .start(start), .dut_out(o0), .a(a0), .b(b0), .busy(busy0),
    .done(done0), .pass(pass0), .err_count(e0), .fail_vec(f0));
  gate_checker #(.HOLD_CYCLES(4), .TRUTH(4'b1111)) u_one (
    .clk(clk), .rst(rst), .start(start), .dut_out(o1), .a(a1), .b(b1), .busy(busy1),
    .done(done1), .pass(pass1), .err_count(e1), .fail_vec(f1));
  gate_checker #(.HOLD_CYCLES(4), .TRUTH(TRUTH_XOR)) u_xor (
    .clk(clk), .rst(rst), .start(start), .dut_out(o2), .a(a2), .b(b2), .busy(busy2),
    .done(done2), .pass(pass2), .err_count(e2), .fail_vec(f2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] model;
    logic [2:0] ea, eo, ex;
    logic [3:0] fa, fo, fx;
  } row_t;
  row_t rows[4];

  task automatic sweep(input row_t r);
    int n = 0;
    mode = r.model;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("sweep start clears", {done0, busy0, e0, f0, e1, f1}, {2'b01, 3'd0, 4'd0, 3'd0, 4'd0});
    while (!done0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("sweep completes", done0, 1);
    chk("and err", e0, r.ea);
    chk("and fail_vec", f0, r.fa);
    chk("and pass", pass0, r.ea == 0);
    chk("ones err", e1, r.eo);
    chk("ones fail_vec", f1, r.fo);
    chk("ones pass", pass1, r.eo == 0);
    chk("xor err", e2, r.ex);
    chk("xor fail_vec", f2, r.fx);
    chk("xor pass", pass2, r.ex == 0);
    chk("done holds 11", {a0, b0, busy0}, 3'b110);
  endtask

  initial begin
    rows[0] = '{model: 2'd0, ea: 3'd0, fa: 4'b0000, eo: 3'd3, fo: 4'b0111, ex: 3'd3, fx: 4'b1110};
    rows[1] = '{model: 2'd1, ea: 3'd1, fa: 4'b1000, eo: 3'd4, fo: 4'b1111, ex: 3'd2, fx: 4'b0110};
    rows[2] = '{model: 2'd2, ea: 3'd3, fa: 4'b0111, eo: 3'd0, fo: 4'b0000, ex: 3'd2, fx: 4'b1001};
    rows[3] = '{model: 2'd3, ea: 3'd3, fa: 4'b1110, eo: 3'd2, fo: 4'b1001, ex: 3'd0, fx: 4'b0000};
    repeat (2) @(negedge clk);
    chk("reset state", {a0, b0, busy0, done0, pass0, e0, f0}, 0);
    rst = 0;
    @(negedge clk);
    chk("idle state", {a0, b0, busy0, done0, pass0}, 0);
    // exact cycle timing of an AND sweep, with start pulses mid-run that must be ignored
    mode = 0;
    start = 1;
    @(negedge clk) start = 0;
    for (int c = 1; c <= 17; c++) begin
      if (c <= 16) chk($sformatf("cycle %0d vec", c), {a0, b0, busy0, done0}, {2'((c - 1) / 4), 2'b10});
      else chk("cycle 17 done", {a0, b0, busy0, done0, pass0, e0, f0}, {4'b1101, 1'b1, 3'd0, 4'd0});
      start = (c == 3 || c == 10);
      @(negedge clk);
    end
    start = 0;
    // stuck-at-1 leaves DONE with errors before the XOR sweep restarts from DONE
    for (int i = 0; i < 4; i++) sweep(rows[i]);
    // reset mid-sweep
    mode = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (6) @(negedge clk);
    chk("pre-reset ones err", e1, 1);
    rst = 1;
    @(negedge clk) rst = 0;
    chk("mid-sweep reset", {a0, b0, busy0, done0, e0, e1}, 0);
    sweep(rows[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
